// File: rtl/mem_access_unit_pkg.sv
// mem_access_unit_pkg: funct3 load/store encodings and access FSM states shared by the core
package mem_access_unit_pkg;
    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;
    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} mau_state_t;
endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: little-endian lane extract/extend, sub-word merge and request legality check
module mem_lane_align
    import mem_access_unit_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic        is_write,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] old_word,
    input  logic [31:0] wdata,
    output logic [31:0] load_value,
    output logic [31:0] merged_word,
    output logic        bad
);
    logic [4:0]  byte_sh;
    logic [4:0]  half_sh;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic        illegal;
    logic        misaligned;
    assign byte_sh = {addr_lo, 3'b000};
    assign half_sh = {addr_lo[1], 4'b0000};
    assign lane_b = 8'(old_word >> byte_sh);
    assign lane_h = 16'(old_word >> half_sh);
    assign load_value = funct3 == F3_B  ? {{24{lane_b[7]}}, lane_b} :
                        funct3 == F3_BU ? {24'd0, lane_b} :
                        funct3 == F3_H  ? {{16{lane_h[15]}}, lane_h} :
                        funct3 == F3_HU ? {16'd0, lane_h} : old_word;
    assign merged_word = funct3 == F3_B ? (old_word & ~(32'h0000_00ff << byte_sh)) | ({24'd0, wdata[7:0]} << byte_sh) :
                         funct3 == F3_H ? (old_word & ~(32'h0000_ffff << half_sh)) | ({16'd0, wdata[15:0]} << half_sh) :
                         wdata;
    assign illegal = is_write ? funct3 > F3_W : (funct3 == 3'd3 || funct3 > F3_HU);
    assign misaligned = (funct3[1:0] == 2'd1 && addr_lo[0]) || (funct3[1:0] == 2'd2 && addr_lo != 2'd0);
    assign bad = illegal || misaligned;
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store initiator for the word-addressed data memory with read-modify-write sub-word stores
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_error,
    output logic              mem_write_enable,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_write_data,
    input  logic [DATA_W-1:0] mem_read_data
);
    mau_state_t        state;
    mau_state_t        state_next;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] old_q;
    logic [DATA_W-1:0] load_value;
    logic [DATA_W-1:0] merged_word;
    logic [2:0]        funct3_q;
    logic              write_q;
    logic              bad;
    logic              in_idle;
    assign in_idle = state == IDLE;
    assign req_ready = in_idle;
    assign resp_valid = state == RESP;
    assign mem_write_enable = state == WRITE;
    assign mem_address = (state == READ || state == WRITE) ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
    assign mem_write_data = state == WRITE ? merged_word : '0;
    // In IDLE the lane logic judges the incoming request; afterwards it works on the captured one.
    mem_lane_align u_align (
        .funct3      (in_idle ? req_funct3 : funct3_q),
        .is_write    (in_idle ? req_write : write_q),
        .addr_lo     (in_idle ? req_addr[1:0] : addr_q[1:0]),
        .old_word    (state == READ ? mem_read_data : old_q),
        .wdata       (wdata_q),
        .load_value  (load_value),
        .merged_word (merged_word),
        .bad         (bad)
    );
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req_valid) state_next = bad ? RESP : (req_write && req_funct3 == F3_W) ? WRITE : READ;
            READ:    state_next = write_q ? WRITE : RESP;
            WRITE:   state_next = RESP;
            default: state_next = IDLE;
        endcase
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            old_q      <= '0;
            funct3_q   <= '0;
            write_q    <= 1'b0;
            resp_rdata <= '0;
            resp_error <= 1'b0;
        end else begin
            state <= state_next;
            if (in_idle && req_valid) begin
                addr_q   <= req_addr;
                wdata_q  <= req_wdata;
                funct3_q <= req_funct3;
                write_q  <= req_write;
            end
            if (state == READ) old_q <= mem_read_data;
            if (state_next == RESP && state != RESP) begin
                resp_error <= in_idle;
                resp_rdata <= (state == READ && !write_q) ? load_value : '0;
            end
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed load/store vectors checked against a byte-level model every cycle
module tb_mem_access_unit;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        req_ready, resp_valid, resp_error, mem_write_enable;
    logic [31:0] resp_rdata, mem_address, mem_write_data, mem_read_data;
    logic [31:0] mem [64];
    logic [31:0] ref_mem [64];
    int checks = 0;
    int errors = 0;
    int k, lat, rd_k, wr_k, resp_k, wr_seen_k, writes;
    bit busy = 0;
    logic [31:0] exp_rdata, exp_wdata, exp_waddr, last_rdata, got_rdata;
    logic        exp_err, got_err;

    always #5 clock = ~clock;

    mem_access_unit #(.ADDR_W(32), .DATA_W(32)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_error(resp_error),
        .mem_write_enable(mem_write_enable), .mem_address(mem_address),
        .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
    );

    assign mem_read_data = mem_address < 32'd256 ? mem[mem_address[7:2]] : '0;
    always @(posedge clock) if (mem_write_enable && mem_address < 32'd256) mem[mem_address[7:2]] <= mem_write_data;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    function automatic int access_size(input logic [2:0] f3);
        return f3[1:0] == 2'd0 ? 1 : f3[1:0] == 2'd1 ? 2 : 4;
    endfunction

    function automatic logic model_err(input logic w, input logic [2:0] f3, input logic [31:0] a);
        bit legal = w ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        return !legal || (a % access_size(f3) != 0);
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] w, input logic [1:0] a);
        int n = access_size(f3);
        int v = 0;
        if (n == 4) return w;
        for (int i = n - 1; i >= 0; i--) v = v * 256 + int'(w[8 * (int'(a) + i) +: 8]);
        if (f3 < 3'd4 && v >= (1 << (8 * n - 1))) v -= (1 << (8 * n));
        return 32'(v);
    endfunction

    function automatic logic [31:0] model_merge(input logic [2:0] f3, input logic [31:0] w, input logic [1:0] a, input logic [31:0] d);
        logic [31:0] r = w;
        for (int i = 0; i < access_size(f3); i++) r[8 * (int'(a) + i) +: 8] = d[8 * i +: 8];
        return r;
    endfunction

    always @(negedge clock) begin
        if (reset) begin
            busy = 0;
            last_rdata = '0;
            check("rst_req_ready", req_ready, 1);
            check("rst_resp_valid", resp_valid, 0);
            check("rst_resp_error", resp_error, 0);
            check("rst_resp_rdata", resp_rdata, 0);
            check("rst_we", mem_write_enable, 0);
            check("rst_addr", mem_address, 0);
            check("rst_wdata", mem_write_data, 0);
        end else if (busy) begin
            k++;
            check("req_ready_busy", req_ready, 0);
            check("resp_valid", resp_valid, k == lat);
            check("we", mem_write_enable, k == wr_k);
            check("mem_address", mem_address, (k == rd_k || k == wr_k) ? exp_waddr : 0);
            check("mem_wdata", mem_write_data, k == wr_k ? exp_wdata : 0);
            check("resp_rdata", resp_rdata, k == lat ? exp_rdata : last_rdata);
            if (mem_write_enable) begin
                writes++;
                wr_seen_k = k;
            end
            if (k == wr_k && exp_waddr < 256) ref_mem[exp_waddr[7:2]] = exp_wdata;
            if (k == lat) begin
                check("resp_error", resp_error, exp_err);
                last_rdata = exp_rdata;
                resp_k = k;
                got_rdata = resp_rdata;
                got_err = resp_error;
                busy = 0;
            end
        end else begin
            check("idle_ready", req_ready, 1);
            check("idle_resp_valid", resp_valid, 0);
            check("idle_we", mem_write_enable, 0);
            check("idle_addr", mem_address, 0);
            check("idle_wdata", mem_write_data, 0);
            check("idle_rdata_hold", resp_rdata, last_rdata);
            if (req_valid) begin
                exp_err = model_err(req_write, req_funct3, req_addr);
                exp_waddr = req_addr & ~32'd3;
                exp_rdata = '0;
                exp_wdata = '0;
                if (exp_err) begin
                    lat = 1; rd_k = 0; wr_k = 0;
                end else if (!req_write) begin
                    lat = 2; rd_k = 1; wr_k = 0;
                    exp_rdata = model_load(req_funct3, req_addr < 256 ? ref_mem[req_addr[7:2]] : 0, req_addr[1:0]);
                end else if (req_funct3 == 3'd2) begin
                    lat = 2; rd_k = 0; wr_k = 1;
                    exp_wdata = req_wdata;
                end else begin
                    lat = 3; rd_k = 1; wr_k = 2;
                    exp_wdata = model_merge(req_funct3, req_addr < 256 ? ref_mem[req_addr[7:2]] : 0, req_addr[1:0], req_wdata);
                end
                k = 0;
                busy = 1;
            end
        end
    end

    task automatic issue(input logic w, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        int n = 0;
        while (!req_ready && n < 20) begin
            @(posedge clock); #1;
            n++;
        end
        req_valid = 1'b1; req_write = w; req_funct3 = f3; req_addr = a; req_wdata = d;
        @(posedge clock); #1;
        req_valid = 1'b0;
    endtask

    task automatic do_req(input logic w, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        int n = 0;
        writes = 0;
        wr_seen_k = 0;
        resp_k = 0;
        issue(w, f3, a, d);
        while (busy && n < 20) begin
            @(posedge clock); #1;
            n++;
        end
        check("resp_timeout", busy, 0);
    endtask

    initial begin
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        @(posedge clock); #1;
        do_req(1, 3'd2, 32'h10, 32'h8899AABB);
        check("setup_sw_latency", resp_k, 2);
        check("setup_sw_writes", writes, 1);
        do_req(0, 3'd2, 32'h10, 32'h0);
        check("t1_lw_data", got_rdata, 32'h8899AABB);
        check("t1_model_pin", exp_rdata, 32'h8899AABB);
        check("t1_latency", resp_k, 2);
        check("t1_error", got_err, 0);
        check("t1_no_write", writes, 0);
        do_req(1, 3'd2, 32'h10, 32'h80FF7F01);
        do_req(0, 3'd0, 32'h13, 32'h0);
        check("t2_lb", got_rdata, 32'hFFFFFF80);
        do_req(0, 3'd4, 32'h13, 32'h0);
        check("t2_lbu", got_rdata, 32'h00000080);
        do_req(0, 3'd1, 32'h13, 32'h0);
        check("t2_lh_mis_err", got_err, 1);
        check("t2_lh_mis_lat", resp_k, 1);
        do_req(0, 3'd1, 32'h12, 32'h0);
        check("t2_lh", got_rdata, 32'hFFFF80FF);
        do_req(0, 3'd5, 32'h12, 32'h0);
        check("t2_lhu", got_rdata, 32'h000080FF);
        do_req(1, 3'd2, 32'h20, 32'h11223344);
        do_req(1, 3'd0, 32'h21, 32'h000000AA);
        check("t3_sb_writes", writes, 1);
        check("t3_sb_write_cycle", wr_seen_k, 2);
        check("t3_sb_latency", resp_k, 3);
        check("t3_sb_mem", mem[8], 32'h1122AA44);
        check("t3_model_pin", ref_mem[8], 32'h1122AA44);
        check("t3_sb_rdata", got_rdata, 0);
        do_req(1, 3'd1, 32'h23, 32'h0000BEEF);
        check("t4_sh_err", got_err, 1);
        check("t4_sh_lat", resp_k, 1);
        check("t4_sh_writes", writes, 0);
        check("t4_sh_mem", mem[8], 32'h1122AA44);
        do_req(0, 3'd2, 32'h06, 32'h0);
        check("t4_lw_err", got_err, 1);
        check("t4_lw_lat", resp_k, 1);
        check("t4_lw_rdata", got_rdata, 0);
        do_req(0, 3'd3, 32'h40, 32'h0);
        check("t4_f3_err", got_err, 1);
        check("t4_f3_lat", resp_k, 1);
        do_req(1, 3'd2, 32'h30, 32'hDEADBEEF);
        check("t5_sw_write_cycle", wr_seen_k, 1);
        do_req(0, 3'd2, 32'h30, 32'h0);
        check("t5_lw_data", got_rdata, 32'hDEADBEEF);
        check("t5_lw_lat", resp_k, 2);
        do_req(1, 3'd2, 32'h38, 32'h0BADF00D);
        writes = 0;
        issue(1, 3'd0, 32'h39, 32'h00000077);
        check("t6_in_read", req_ready, 0);
        reset = 1'b1;
        #1;
        check("t6_async_idle", req_ready, 1);
        check("t6_async_we", mem_write_enable, 0);
        @(posedge clock); @(posedge clock); #1;
        reset = 1'b0;
        @(posedge clock); #1;
        check("t6_ready_after", req_ready, 1);
        check("t6_no_write", writes, 0);
        check("t6_mem", mem[14], 32'h0BADF00D);
        @(posedge clock); #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
